// File: rtl/video_timing_gen_if.sv
// Timing bus between the video timing generator and its display / frame-buffer consumers.
interface video_timing_gen_if #(
    parameter int unsigned COL_W  = 10,
    parameter int unsigned ROW_W  = 10,
    parameter int unsigned ADDR_W = 20
) ();
    logic              enable;
    logic              restart;
    logic              pixel_clk;
    logic              pixel_tick;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic              active;
    logic              hsync;
    logic              vsync;
    logic              line_start;
    logic              frame_start;

    modport master (
        input  enable, restart,
        output pixel_clk, pixel_tick, col, row, addr, active,
               hsync, vsync, line_start, frame_start
    );

    modport slave (
        output enable, restart,
        input  pixel_clk, pixel_tick, col, row, addr, active,
               hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel divider, col/row sweep, sync/active decode
// and linear frame-buffer read address with line/frame start strobes.
module video_timing_gen #(
    parameter int unsigned CLK_DIV  = 6,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned COL_W    = 10,
    parameter int unsigned ROW_W    = 10,
    parameter int unsigned ADDR_W   = 20
) (
    input logic              clk,
    input logic              n_rst,
    video_timing_gen_if.master vt
);
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC;
    localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC;
    localparam int unsigned DIV_W     = $clog2(CLK_DIV);
    localparam logic        HS_ON     = 1'(HS_POL);
    localparam logic        VS_ON     = 1'(VS_POL);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              pclk_q, pclk_d;
    logic              tick_q, tick_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              active_q, active_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              ls_q, ls_d;
    logic              fs_q, fs_d;
    logic              advance, col_wrap, row_wrap;

    // Next-state: restart beats enable; decode uses the new position so flags track col/row.
    always_comb begin
        div_d    = div_q;
        pclk_d   = pclk_q;
        tick_d   = 1'b0;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        active_d = active_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        ls_d     = 1'b0;
        fs_d     = 1'b0;
        advance  = 1'b0;
        col_wrap = 1'b0;
        row_wrap = 1'b0;

        if (vt.restart) begin
            div_d    = '0;
            pclk_d   = 1'b1;
            col_d    = '0;
            row_d    = '0;
            addr_d   = '0;
            active_d = 1'b1;
            hsync_d  = ~HS_ON;
            vsync_d  = ~VS_ON;
            ls_d     = 1'b1;
            fs_d     = 1'b1;
        end else if (vt.enable) begin
            advance = (div_q == DIV_W'(CLK_DIV - 1));
            div_d   = advance ? '0 : div_q + DIV_W'(1);
            pclk_d  = (div_d < DIV_W'(CLK_DIV / 2));
            if (advance) begin
                col_wrap = (col_q == COL_W'(H_TOTAL - 1));
                row_wrap = (row_q == ROW_W'(V_TOTAL - 1));
                tick_d   = 1'b1;
                col_d    = col_wrap ? '0 : col_q + COL_W'(1);
                if (col_wrap) begin
                    row_d = row_wrap ? '0 : row_q + ROW_W'(1);
                end
                // Frame wrap wins over the active-pixel increment.
                if (col_wrap && row_wrap) begin
                    addr_d = '0;
                end else if (active_q) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                active_d = (col_d < COL_W'(H_ACTIVE)) && (row_d < ROW_W'(V_ACTIVE));
                hsync_d  = ((col_d >= COL_W'(H_SYNC_LO)) && (col_d < COL_W'(H_SYNC_HI)))
                           ? HS_ON : ~HS_ON;
                vsync_d  = ((row_d >= ROW_W'(V_SYNC_LO)) && (row_d < ROW_W'(V_SYNC_HI)))
                           ? VS_ON : ~VS_ON;
                ls_d     = col_wrap;
                fs_d     = col_wrap && row_wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_q    <= '0;
            pclk_q   <= 1'b1;
            tick_q   <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            active_q <= 1'b1;
            hsync_q  <= ~HS_ON;
            vsync_q  <= ~VS_ON;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            pclk_q   <= pclk_d;
            tick_q   <= tick_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            active_q <= active_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    assign vt.pixel_clk   = pclk_q;
    assign vt.pixel_tick  = tick_q;
    assign vt.col         = col_q;
    assign vt.row         = row_q;
    assign vt.addr        = addr_q;
    assign vt.active      = active_q;
    assign vt.hsync       = hsync_q;
    assign vt.vsync       = vsync_q;
    assign vt.line_start  = ls_q;
    assign vt.frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 timing plus a tiny 7x6 frame with inverted sync polarity.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic n_rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    video_timing_gen_if #(.COL_W(10), .ROW_W(10), .ADDR_W(20)) vt0 ();
    video_timing_gen_if #(.COL_W(3),  .ROW_W(3),  .ADDR_W(4))  vt1 ();

    video_timing_gen u_dflt (.clk(clk), .n_rst(n_rst), .vt(vt0));

    video_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .COL_W(3), .ROW_W(3), .ADDR_W(4)
    ) u_small (.clk(clk), .n_rst(n_rst), .vt(vt1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_dflt(input string tag, input int c, input int r, input int a,
                              input int act, input int hs, input int vs, input int tk,
                              input int ls, input int fs, input int pc);
        check({tag, ".col"},   32'(vt0.col),         32'(c));
        check({tag, ".row"},   32'(vt0.row),         32'(r));
        check({tag, ".addr"},  32'(vt0.addr),        32'(a));
        check({tag, ".act"},   32'(vt0.active),      32'(act));
        check({tag, ".hs"},    32'(vt0.hsync),       32'(hs));
        check({tag, ".vs"},    32'(vt0.vsync),       32'(vs));
        check({tag, ".tick"},  32'(vt0.pixel_tick),  32'(tk));
        check({tag, ".ls"},    32'(vt0.line_start),  32'(ls));
        check({tag, ".fs"},    32'(vt0.frame_start), 32'(fs));
        check({tag, ".pclk"},  32'(vt0.pixel_clk),   32'(pc));
    endtask

    task automatic check_small(input string tag, input int c, input int r, input int a,
                               input int act, input int hs, input int vs, input int tk,
                               input int ls, input int fs, input int pc);
        check({tag, ".col"},   32'(vt1.col),         32'(c));
        check({tag, ".row"},   32'(vt1.row),         32'(r));
        check({tag, ".addr"},  32'(vt1.addr),        32'(a));
        check({tag, ".act"},   32'(vt1.active),      32'(act));
        check({tag, ".hs"},    32'(vt1.hsync),       32'(hs));
        check({tag, ".vs"},    32'(vt1.vsync),       32'(vs));
        check({tag, ".tick"},  32'(vt1.pixel_tick),  32'(tk));
        check({tag, ".ls"},    32'(vt1.line_start),  32'(ls));
        check({tag, ".fs"},    32'(vt1.frame_start), 32'(fs));
        check({tag, ".pclk"},  32'(vt1.pixel_clk),   32'(pc));
    endtask

    initial begin
        n_rst       = 1'b0;
        vt0.enable  = 1'b1;
        vt0.restart = 1'b0;
        vt1.enable  = 1'b0;
        vt1.restart = 1'b0;
        repeat (2) @(negedge clk);
        check_dflt("reset", 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);

        // Divider: tick every 6 clks, pixel_clk 3 high / 3 low.
        n_rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("div.pclk", 32'(vt0.pixel_clk), ((k % 6) < 3) ? 32'd1 : 32'd0);
            check("div.tick", 32'(vt0.pixel_tick), ((k % 6) == 0) ? 32'd1 : 32'd0);
            if (k == 6) check_dflt("tick1", 1, 0, 1, 1, 1, 1, 1, 0, 0, 1);
        end
        check_dflt("tick2", 2, 0, 2, 1, 1, 1, 1, 0, 0, 1);

        // Line 0 sweep through the wrap into row 1.
        for (int c = 3; c <= 800; c++) begin
            int col_e, row_e, addr_e, act_e, hs_e;
            repeat (6) @(negedge clk);
            col_e  = c % 800;
            row_e  = c / 800;
            addr_e = (c < 640) ? c : 640;
            act_e  = (col_e < 640) ? 1 : 0;
            hs_e   = (col_e >= 656 && col_e <= 751) ? 0 : 1;
            check_dflt("hsweep", col_e, row_e, addr_e, act_e, hs_e, 1, 1,
                       (col_e == 0) ? 1 : 0, 0, 1);
        end

        // Enable gating with the divider parked at 3.
        repeat (3) @(negedge clk);
        check("gate.pre.pclk", 32'(vt0.pixel_clk), 32'd0);
        vt0.enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_dflt("gate.hold", 0, 1, 640, 1, 1, 1, 0, 0, 0, 0);
        end
        vt0.enable = 1'b1;
        repeat (2) @(negedge clk);
        check("gate.early", 32'(vt0.pixel_tick), 32'd0);
        @(negedge clk);
        check_dflt("gate.resume", 1, 1, 641, 1, 1, 1, 1, 0, 0, 1);

        // Restart from mid-line.
        repeat (299 * 6) @(negedge clk);
        check_dflt("pre_restart", 300, 1, 940, 1, 1, 1, 1, 0, 0, 1);
        vt0.restart = 1'b1;
        @(negedge clk);
        vt0.restart = 1'b0;
        check_dflt("restart", 0, 0, 0, 1, 1, 1, 0, 1, 1, 1);
        @(negedge clk);
        check_dflt("restart+1", 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
        repeat (5) @(negedge clk);
        check_dflt("restart.tick", 1, 0, 1, 1, 1, 1, 1, 0, 0, 1);

        // Async reset between clock edges.
        repeat (24) @(negedge clk);
        check_dflt("pre_arst", 5, 0, 5, 1, 1, 1, 1, 0, 0, 1);
        #2 n_rst = 1'b0;
        #1;
        check_dflt("arst", 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        check("arst.early", 32'(vt0.pixel_tick), 32'd0);
        @(negedge clk);
        check_dflt("arst.first", 1, 0, 1, 1, 1, 1, 1, 0, 0, 1);

        // Small frame, active-high syncs idle at 0.
        check_small("s.reset", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        vt1.enable = 1'b1;
        for (int k = 1; k <= 84; k++) begin
            int col_e, row_e, addr_e;
            @(negedge clk);
            check("s.gap.tick", 32'(vt1.pixel_tick), 32'd0);
            check("s.gap.pclk", 32'(vt1.pixel_clk), 32'd0);
            @(negedge clk);
            col_e  = k % 7;
            row_e  = (k / 7) % 6;
            addr_e = (row_e < 3) ? (row_e * 4 + ((col_e < 4) ? col_e : 4)) : 12;
            check_small("s.tick", col_e, row_e, addr_e,
                        (col_e < 4 && row_e < 3) ? 1 : 0,
                        (col_e == 5) ? 1 : 0,
                        (row_e == 4) ? 1 : 0,
                        1,
                        (col_e == 0) ? 1 : 0,
                        (col_e == 0 && row_e == 0) ? 1 : 0,
                        1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
